reg_file_clr: RTL and testbench
===============================

Name: reg_file_clr

Overview:
- 9-bit general-purpose register file; directly downstream of the writeback select stage, consuming its WriteData and committing it on the clock edge.
- Two combinational read ports feed the ALU operand path.
- Built-in clear sequencer zeroes every entry, one per cycle, after reset. It raises Busy so the control unit can hold the PC until the file is valid.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 9, width of each register and of the read/write data ports.
- NUM_REGS, 8, number of registers; a power of two, minimum 2.
- ADDR_W, 3, address width; equals log2(NUM_REGS).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- RegWrite  input  1  write enable for the current cycle.
- WriteReg  input  ADDR_W  destination register index.
- WriteData  input  DATA_W  data to commit (from writeback select).
- ReadReg1  input  ADDR_W  read port 1 index.
- ReadReg2  input  ADDR_W  read port 2 index.
- ReadData1  output  DATA_W  read port 1 data, combinational.
- ReadData2  output  DATA_W  read port 2 data, combinational.
- Busy  output  1  registered; high while clear sequencer runs.
- WriteDropped  output  1  registered one-cycle pulse; a requested write was discarded.

Behaviour:
- Storage: NUM_REGS x DATA_W array. Entries are zeroed only by the sequencer, never directly by reset.
- States: CLEAR, READY. State, ClearPtr (ADDR_W bits), Busy and WriteDropped are registered.
- Reset edge:
  - state = CLEAR, ClearPtr = 0, Busy = 1, WriteDropped = 0.
  - While reset is held, state stays CLEAR and ClearPtr stays 0; no array write occurs.
- CLEAR, reset low, each edge:
  - mem[ClearPtr] = 0; ClearPtr increments.
  - On the edge that clears entry NUM_REGS-1, ClearPtr wraps to 0, state goes to READY and Busy goes to 0.
  - Busy is therefore high for exactly NUM_REGS cycles after reset release.
- CLEAR, write requests: RegWrite is ignored (array untouched by user writes). WriteDropped = RegWrite, registered on that edge.
- READY, each edge:
  - If RegWrite = 1 and WriteReg != 0: mem[WriteReg] = WriteData.
  - If WriteReg = 0: no write, and WriteDropped = 0. A write to register 0 is architectural, not a drop.
  - WriteDropped = 0 in READY.
- Reads:
  - ReadDataN = 0 when ReadRegN = 0 or Busy = 1. Otherwise ReadDataN = mem[ReadRegN].
  - Both ports are independent; identical indices on both ports are legal.
- Same-cycle read/write to the same index: behaviour is set by the optional feature (below).
- Reset mid-CLEAR: sequencer restarts at ClearPtr 0, and Busy stays high for a full NUM_REGS cycles after release.
- Reset in READY: returns to CLEAR; all prior contents are discarded by the subsequent sweep.
- No X may propagate to ReadData1/2 at any point after the first reset edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass, combinational. In READY, if RegWrite = 1, WriteReg != 0 and ReadRegN == WriteReg, then ReadDataN = WriteData in the same cycle.
- Not defined: ReadDataN returns the pre-edge stored value; the new value is visible from the cycle after the edge.
- Either way: register 0 still reads 0, and Busy still forces 0.

Test Plan:
- Clear sequence: hold reset 3 cycles, release. Busy = 1 for exactly 8 cycles then 0; all 8 entries read 0x000 on both ports.
- Write during clear: RegWrite = 1, WriteReg = 5, WriteData = 0x1AB at 2nd cycle after release. WriteDropped pulses 1 for one cycle; after Busy falls, reg5 reads 0x000.
- Normal write/read: write 0x155 to reg3, 0x0AA to reg7, then ReadReg1 = 3, ReadReg2 = 7. ReadData1 = 0x155, ReadData2 = 0x0AA. A write of 0x1FF to reg0 keeps reading 0x000 with WriteDropped = 0.
- Same-cycle read/write: reg2 holds 0x011; write 0x1C3 to reg2 while ReadReg1 = 2.
  - With REGFILE_BYPASS_EN: ReadData1 = 0x1C3 in that cycle.
  - Without it: ReadData1 = 0x011 in that cycle, then 0x1C3 next cycle.
- Reset mid-clear: assert reset 1 cycle when ClearPtr = 4, release. Busy stays high another full 8 cycles; final contents all 0x000.
- Reset in READY: reg6 = 0x0F0; assert reset. Busy = 1 for 8 cycles after release, and reg6 reads 0x000 thereafter.

Source files
------------

// File: rtl/reg_file_clr_if.sv
// Register-file bus: write port, two read ports and the clear-sequencer status flags.
interface reg_file_clr_if #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned ADDR_W = 3
);
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              Busy;
  logic              WriteDropped;

  modport master (
    output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
    input  ReadData1, ReadData2, Busy, WriteDropped
  );

  modport slave (
    input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
    output ReadData1, ReadData2, Busy, WriteDropped
  );
endinterface

// File: rtl/reg_file_clr.sv
// Register file with a post-reset clear sequencer; register 0 reads as zero.
// Define REGFILE_BYPASS_EN for combinational write-through on same-index read/write.
module reg_file_clr #(
  parameter int unsigned DATA_W   = 9,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 3
) (
  input logic           clk,
  input logic           reset,
  reg_file_clr_if.slave bus
);

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clear_ptr_q, clear_ptr_d;
  logic              busy_q, busy_d;
  logic              write_dropped_q, write_dropped_d;

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    state_d         = state_q;
    clear_ptr_d     = clear_ptr_q;
    busy_d          = busy_q;
    write_dropped_d = 1'b0;
    mem_we          = 1'b0;
    mem_waddr       = clear_ptr_q;
    mem_wdata       = '0;
    unique case (state_q)
      CLEAR: begin
        mem_we          = 1'b1;
        write_dropped_d = bus.RegWrite;
        clear_ptr_d     = clear_ptr_q + ADDR_W'(1);
        if (clear_ptr_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d = READY;
          busy_d  = 1'b0;
        end
      end
      READY: begin
        busy_d = 1'b0;
        if (bus.RegWrite && (bus.WriteReg != '0)) begin
          mem_we    = 1'b1;
          mem_waddr = bus.WriteReg;
          mem_wdata = bus.WriteData;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= CLEAR;
      clear_ptr_q     <= '0;
      busy_q          <= 1'b1;
      write_dropped_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      clear_ptr_q     <= clear_ptr_d;
      busy_q          <= busy_d;
      write_dropped_q <= write_dropped_d;
    end
  end

  // Storage has no reset; the sweep initialises it and Busy masks reads until done.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  logic [DATA_W-1:0] rd1, rd2;

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (!busy_q && (bus.ReadReg1 != '0)) rd1 = mem_q[bus.ReadReg1];
    if (!busy_q && (bus.ReadReg2 != '0)) rd2 = mem_q[bus.ReadReg2];
`ifdef REGFILE_BYPASS_EN
    if (!busy_q && (state_q == READY) && bus.RegWrite && (bus.WriteReg != '0)) begin
      if (bus.ReadReg1 == bus.WriteReg) rd1 = bus.WriteData;
      if (bus.ReadReg2 == bus.WriteReg) rd2 = bus.WriteData;
    end
`endif
  end

  assign bus.ReadData1    = rd1;
  assign bus.ReadData2    = rd2;
  assign bus.Busy         = busy_q;
  assign bus.WriteDropped = write_dropped_q;

endmodule

// File: tb/tb_reg_file_clr.sv
// Scoreboard bench for reg_file_clr: stimulus queues expectations per cycle, a monitor checks them.
module tb_reg_file_clr;

  localparam int DW = 9;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic reset;
  int unsigned cyc = 0;

  reg_file_clr_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  reg_file_clr #(.DATA_W(DW), .NUM_REGS(8), .ADDR_W(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    int          kind;   // 0 rd1, 1 rd2, 2 busy, 3 write_dropped
    logic [8:0]  val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic expect_val(input int kind, input logic [8:0] val, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic rw, input int wr, input logic [8:0] wd,
                     input int r1, input int r2);
    bus.RegWrite  = rw;
    bus.WriteReg  = AW'(wr);
    bus.WriteData = wd;
    bus.ReadReg1  = AW'(r1);
    bus.ReadReg2  = AW'(r2);
  endtask

  // Monitor: pops every expectation due in the current cycle and compares at negedge.
  always @(negedge clk) begin
    logic [8:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      case (e.kind)
        0:       act = bus.ReadData1;
        1:       act = bus.ReadData2;
        2:       act = {8'd0, bus.Busy};
        default: act = {8'd0, bus.WriteDropped};
      endcase
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
      end else if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.val, cyc);
      end
    end
  end

  task automatic clear_window(input string tag);
    for (int i = 0; i < 8; i++) begin
      expect_val(2, 9'd1, {tag, "_busy_hi"});
      expect_val(0, 9'd0, {tag, "_rd1_masked"});
      step();
    end
    expect_val(2, 9'd0, {tag, "_busy_lo"});
    expect_val(3, 9'd0, {tag, "_wdrop_lo"});
  endtask

  task automatic read_all_zero(input string tag);
    for (int r = 0; r < 8; r += 2) begin
      drv(1'b0, 0, 9'd0, r, r + 1);
      expect_val(0, 9'd0, {tag, "_rd1_zero"});
      expect_val(1, 9'd0, {tag, "_rd2_zero"});
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drv(1'b0, 0, 9'd0, 3, 5);

    // Reset held for three edges.
    step();
    expect_val(2, 9'd1, "rst_busy");
    expect_val(3, 9'd0, "rst_wdrop");
    expect_val(0, 9'd0, "rst_rd1");
    expect_val(1, 9'd0, "rst_rd2");
    step();
    step();
    reset = 1'b0;

    // Initial sweep with a write request in the second cycle after release.
    for (int i = 0; i < 8; i++) begin
      expect_val(2, 9'd1, "clr_busy_hi");
      if (i == 1) drv(1'b1, 5, 9'h1AB, 5, 0);
      else        drv(1'b0, 0, 9'd0, 5, 0);
      if (i == 2) expect_val(3, 9'd1, "clr_wdrop_pulse");
      else        expect_val(3, 9'd0, "clr_wdrop_lo");
      expect_val(0, 9'd0, "clr_rd_masked");
      step();
    end
    expect_val(2, 9'd0, "clr_busy_lo");
    expect_val(3, 9'd0, "clr_wdrop_after");
    read_all_zero("sweep");

    // Normal writes and reads.
    drv(1'b1, 3, 9'h155, 0, 0);
    step();
    expect_val(3, 9'd0, "wr_no_drop");
    drv(1'b1, 7, 9'h0AA, 0, 0);
    step();
    drv(1'b0, 0, 9'd0, 3, 7);
    expect_val(0, 9'h155, "rd_reg3");
    expect_val(1, 9'h0AA, "rd_reg7");
    step();
    drv(1'b1, 0, 9'h1FF, 0, 3);
    expect_val(0, 9'd0, "reg0_same_cycle");
    expect_val(1, 9'h155, "reg3_hold");
    step();
    drv(1'b0, 0, 9'd0, 0, 0);
    expect_val(0, 9'd0, "reg0_after");
    expect_val(3, 9'd0, "reg0_no_drop");
    step();

    // Same-cycle read/write on reg2.
    drv(1'b1, 2, 9'h011, 0, 0);
    step();
    drv(1'b1, 2, 9'h1C3, 2, 2);
`ifdef REGFILE_BYPASS_EN
    expect_val(0, 9'h1C3, "rw_same_rd1");
    expect_val(1, 9'h1C3, "rw_same_rd2");
`else
    expect_val(0, 9'h011, "rw_same_rd1");
    expect_val(1, 9'h011, "rw_same_rd2");
`endif
    step();
    drv(1'b0, 0, 9'd0, 2, 2);
    expect_val(0, 9'h1C3, "rw_next_rd1");
    expect_val(1, 9'h1C3, "rw_next_rd2");
    step();

    // Reset mid-clear at ClearPtr = 4.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_val(2, 9'd1, "mid_busy_pre");
      step();
    end
    expect_val(2, 9'd1, "mid_busy_at4");
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_window("mid");
    read_all_zero("mid");

    // Reset from READY discards contents.
    drv(1'b1, 6, 9'h0F0, 0, 0);
    step();
    drv(1'b0, 0, 9'd0, 6, 6);
    expect_val(0, 9'h0F0, "reg6_written");
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    drv(1'b0, 0, 9'd0, 6, 6);
    clear_window("rdy");
    expect_val(0, 9'd0, "reg6_cleared_rd1");
    expect_val(1, 9'd0, "reg6_cleared_rd2");
    step();

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
